// File: rtl/pixel_feeder_pkg.sv
// rtl/pixel_feeder_pkg.sv - bpp encodings, line states and pixels-per-word lookup for pixel_feeder
package pixel_feeder_pkg;

    typedef logic [1:0] bpp_t;

    localparam bpp_t BPP_1 = 2'd0;
    localparam bpp_t BPP_2 = 2'd1;
    localparam bpp_t BPP_4 = 2'd2;
    localparam bpp_t BPP_8 = 2'd3;

    localparam int WORD_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Index of the last pixel slot in a word: (16 >> bpp) - 1
    function automatic logic [3:0] ppw_last(input bpp_t bpp);
        case (bpp)
            BPP_1:   return 4'd15;
            BPP_2:   return 4'd7;
            BPP_4:   return 4'd3;
            default: return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/pixel_feeder_if.sv
// rtl/pixel_feeder_if.sv - fetch/shifter signal bundle; underrun_cnt_o present with PIXEL_FEEDER_UNDERRUN_CNT_EN
interface pixel_feeder_if
    import pixel_feeder_pkg::*;
#(
    parameter int WPL_W = 8
);
    bpp_t               bpp_i;
    logic [WPL_W-1:0]   words_per_line_i;
    logic               line_start_i;
    logic               word_valid_i;
    logic [WORD_W-1:0]  word_dat_i;
    logic               word_ready_o;
    logic [WORD_W-1:0]  sr_dat_o;
    logic               sr_load_o;
    logic               sr_shift1_o;
    logic               sr_shift2_o;
    logic               sr_shift4_o;
    logic               sr_shift8_o;
    logic               active_o;
    logic               underrun_o;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    logic [7:0]         underrun_cnt_o;
`endif

    modport master (
        output bpp_i, words_per_line_i, line_start_i, word_valid_i, word_dat_i,
        input  word_ready_o, sr_dat_o, sr_load_o, sr_shift1_o, sr_shift2_o,
               sr_shift4_o, sr_shift8_o, active_o, underrun_o
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
        , input underrun_cnt_o
`endif
    );

    modport slave (
        input  bpp_i, words_per_line_i, line_start_i, word_valid_i, word_dat_i,
        output word_ready_o, sr_dat_o, sr_load_o, sr_shift1_o, sr_shift2_o,
               sr_shift4_o, sr_shift8_o, active_o, underrun_o
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
        , output underrun_cnt_o
`endif
    );

endinterface

// File: rtl/pixel_feeder_fifo.sv
// rtl/pixel_feeder_fifo.sv - synchronous DEPTH x 16 word buffer, head visible without fall-through
module pixel_feeder_fifo
    import pixel_feeder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_q;
    logic [AW:0]       rd_q;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head    = mem[rd_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pixel_feeder.sv
// rtl/pixel_feeder.sv - word buffer and line strobe sequencer for the pixel shifter; PIXEL_FEEDER_UNDERRUN_CNT_EN adds underrun_cnt_o
module pixel_feeder
    import pixel_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WPL_W      = 8
) (
    input  logic          dotclk_i,
    input  logic          reset_i,
    pixel_feeder_if.slave bus
);
    state_t            state_q, state_d;
    bpp_t              bpp_q, bpp_d;
    logic [WPL_W-1:0]  wpl_q, wpl_d;
    logic [WPL_W-1:0]  word_q, word_d;
    logic [WPL_W-1:0]  acc_q, acc_d;
    logic [3:0]        pix_q, pix_d;
    logic [WORD_W-1:0] dat_q, dat_d;
    logic              load_q, load_d;
    logic [3:0]        shift_q, shift_d;
    logic              active_q, active_d;
    logic              underrun_q, underrun_d;

    logic              word_ready;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head;
    logic              full;
    logic              empty;

`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    logic [7:0]        ucnt_q, ucnt_d;
`endif

    pixel_feeder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (dotclk_i),
        .rst   (reset_i),
        .push  (push),
        .pop   (pop),
        .din   (bus.word_dat_i),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // wpl_q doubles as the prefetch limit while idle, so the next line fills up front
    assign word_ready = !full && (acc_q < wpl_q);
    assign push       = bus.word_valid_i && word_ready;

    always_comb begin
        state_d    = state_q;
        bpp_d      = bpp_q;
        wpl_d      = wpl_q;
        word_d     = word_q;
        pix_d      = pix_q;
        acc_d      = acc_q + WPL_W'(push);
        underrun_d = underrun_q;
        dat_d      = '0;
        load_d     = 1'b0;
        shift_d    = 4'b0000;
        active_d   = 1'b0;
        pop        = 1'b0;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
        ucnt_d     = ucnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.line_start_i && (bus.words_per_line_i != '0)) begin
                    state_d    = ST_RUN;
                    bpp_d      = bus.bpp_i;
                    wpl_d      = bus.words_per_line_i;
                    word_d     = '0;
                    pix_d      = '0;
                    underrun_d = 1'b0;
                end
            end
            ST_RUN: begin
                active_d = 1'b1;
                if (pix_q == 4'd0) begin
                    load_d = 1'b1;
                    if (!empty) begin
                        pop   = 1'b1;
                        dat_d = head;
                    end else begin
                        underrun_d = 1'b1;
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
                        if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
`endif
                    end
                end else begin
                    shift_d[bpp_q] = 1'b1;
                end
                if (pix_q == ppw_last(bpp_q)) begin
                    pix_d  = '0;
                    word_d = word_q + WPL_W'(1);
                    if (word_q == wpl_q - WPL_W'(1)) begin
                        state_d = ST_IDLE;
                        acc_d   = WPL_W'(push);
                        wpl_d   = bus.words_per_line_i;
                    end
                end else begin
                    pix_d = pix_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge dotclk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            bpp_q      <= BPP_1;
            wpl_q      <= bus.words_per_line_i;
            word_q     <= '0;
            pix_q      <= '0;
            acc_q      <= '0;
            underrun_q <= 1'b0;
            dat_q      <= '0;
            load_q     <= 1'b0;
            shift_q    <= 4'b0000;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bpp_q      <= bpp_d;
            wpl_q      <= wpl_d;
            word_q     <= word_d;
            pix_q      <= pix_d;
            acc_q      <= acc_d;
            underrun_q <= underrun_d;
            dat_q      <= dat_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            active_q   <= active_d;
        end
    end

`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
    always_ff @(posedge dotclk_i) begin
        if (reset_i) ucnt_q <= 8'd0;
        else         ucnt_q <= ucnt_d;
    end
    assign bus.underrun_cnt_o = ucnt_q;
`endif

    assign bus.word_ready_o = word_ready;
    assign bus.sr_dat_o     = dat_q;
    assign bus.sr_load_o    = load_q;
    assign bus.sr_shift1_o  = shift_q[0];
    assign bus.sr_shift2_o  = shift_q[1];
    assign bus.sr_shift4_o  = shift_q[2];
    assign bus.sr_shift8_o  = shift_q[3];
    assign bus.active_o     = active_q;
    assign bus.underrun_o   = underrun_q;

endmodule

// File: tb/tb_pixel_feeder.sv
// tb/tb_pixel_feeder.sv - directed bench for pixel_feeder with a queue-based line model
module tb_pixel_feeder;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_feeder_if #(.WPL_W(8)) bus ();

    pixel_feeder #(.FIFO_DEPTH(DEPTH), .WPL_W(8)) dut (
        .dotclk_i (clk),
        .reset_i  (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: buffered words, and the remaining strobe schedule of the current line (-1 = load, else shift bpp)
    logic [15:0] mq [$];
    int          sched [$];
    int          acc = 0;
    int          wpl_lim = 0;
    logic        m_underrun = 1'b0;
    int          m_ucnt = 0;
    logic [15:0] e_dat = '0;
    logic        e_load = 1'b0;
    logic [3:0]  e_shift = 4'b0;
    logic        e_active = 1'b0;
    logic        e_ready = 1'b0;
    logic        model_ok = 1'b0;

    always @(posedge clk) begin
        logic rdy;
        logic psh;
        int   k;
        if (rst) begin
            mq.delete();
            sched.delete();
            acc        = 0;
            wpl_lim    = int'(bus.words_per_line_i);
            m_underrun = 1'b0;
            m_ucnt     = 0;
            e_dat = '0; e_load = 1'b0; e_shift = 4'b0; e_active = 1'b0;
        end else begin
            rdy = (mq.size() < DEPTH) && (acc < wpl_lim);
            psh = bus.word_valid_i && rdy;
            e_dat = '0; e_load = 1'b0; e_shift = 4'b0; e_active = 1'b0;
            if (sched.size() != 0) begin
                k = sched.pop_front();
                e_active = 1'b1;
                if (k < 0) begin
                    e_load = 1'b1;
                    if (mq.size() != 0) e_dat = mq.pop_front();
                    else begin
                        m_underrun = 1'b1;
                        if (m_ucnt < 255) m_ucnt++;
                    end
                end else begin
                    e_shift = 4'b0001 << k;
                end
                if (sched.size() == 0) begin
                    acc     = psh ? 1 : 0;
                    wpl_lim = int'(bus.words_per_line_i);
                end else begin
                    acc += psh ? 1 : 0;
                end
            end else begin
                acc += psh ? 1 : 0;
                if (bus.line_start_i && bus.words_per_line_i != 0) begin
                    m_underrun = 1'b0;
                    for (int w = 0; w < int'(bus.words_per_line_i); w++) begin
                        sched.push_back(-1);
                        for (int j = 1; j < (16 >> bus.bpp_i); j++) sched.push_back(int'(bus.bpp_i));
                    end
                end
            end
            if (psh) mq.push_back(bus.word_dat_i);
        end
        e_ready  = (mq.size() < DEPTH) && (acc < wpl_lim);
        model_ok = 1'b1;
    end

    always @(negedge clk) begin
        logic [23:0] act;
        logic [23:0] exp;
        if (model_ok) begin
            act = {bus.sr_dat_o, bus.sr_load_o, bus.sr_shift8_o, bus.sr_shift4_o, bus.sr_shift2_o,
                   bus.sr_shift1_o, bus.active_o, bus.underrun_o, bus.word_ready_o};
            exp = {e_dat, e_load, e_shift, e_active, m_underrun, e_ready};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t actual=%h expected=%h", $time, act, exp);
            end
`ifdef PIXEL_FEEDER_UNDERRUN_CNT_EN
            checks++;
            if (bus.underrun_cnt_o !== 8'(m_ucnt)) begin
                errors++;
                $display("FAIL underrun_cnt t=%0t actual=%0d expected=%0d", $time, bus.underrun_cnt_o, m_ucnt);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        int n = 0;
        @(negedge clk); #1;
        while (!bus.word_ready_o && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) chk("push_timeout", 32'(n), 32'd0);
        else begin
            bus.word_valid_i = 1'b1;
            bus.word_dat_i   = w;
            @(negedge clk); #1;
            bus.word_valid_i = 1'b0;
        end
    endtask

    task automatic start_line(input logic [1:0] b, input int w, input int nxt);
        @(negedge clk); #1;
        bus.bpp_i            = b;
        bus.words_per_line_i = 8'(w);
        bus.line_start_i     = 1'b1;
        @(negedge clk); #1;
        bus.line_start_i     = 1'b0;
        bus.words_per_line_i = 8'(nxt);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sched.size() != 0 || bus.active_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("line_timeout", 32'(n), 32'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        int cnt_a, cnt_l, cnt_s, cnt_b;
        bus.bpp_i = 2'd0; bus.words_per_line_i = 8'd2; bus.line_start_i = 1'b0;
        bus.word_valid_i = 1'b0; bus.word_dat_i = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.sr_dat_o, bus.sr_load_o, bus.sr_shift1_o, bus.sr_shift8_o,
                              bus.active_o, bus.underrun_o}, 32'd0);
        chk("reset_ready", 32'(bus.word_ready_o), 32'd1);
        #1 rst = 1'b0;

        // 1bpp, two words
        push_word(16'hA5A5);
        push_word(16'h0F0F);
        start_line(2'd0, 2, 3);
        @(negedge clk);
        chk("t1_load0", {bus.sr_load_o, bus.sr_dat_o}, {15'd0, 1'b1, 16'hA5A5});
        repeat (15) @(negedge clk);
        chk("t1_shift_last0", 32'(bus.sr_shift1_o), 32'd1);
        @(negedge clk);
        chk("t1_load1", {bus.sr_load_o, bus.sr_dat_o}, {15'd0, 1'b1, 16'h0F0F});
        repeat (16) @(negedge clk);
        chk("t1_idle", {bus.active_o, bus.sr_load_o, bus.sr_shift1_o}, 32'd0);
        wait_done();

        // 8bpp, three words
        push_word(16'h1122); push_word(16'h3344); push_word(16'h5566);
        start_line(2'd3, 3, 3);
        cnt_a = 0; cnt_l = 0; cnt_s = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cnt_a += bus.active_o ? 1 : 0;
            cnt_l += bus.sr_load_o ? 1 : 0;
            cnt_s += bus.sr_shift8_o ? 1 : 0;
        end
        chk("t2_active_cycles", 32'(cnt_a), 32'd6);
        chk("t2_loads", 32'(cnt_l), 32'd3);
        chk("t2_shift8", 32'(cnt_s), 32'd3);
        wait_done();

        // underrun: 2 of 3 words at 2bpp
        push_word(16'hBEEF); push_word(16'hCAFE);
        start_line(2'd1, 3, 4);
        cnt_b = 0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (bus.sr_load_o && bus.sr_dat_o == 16'h0) cnt_b++;
        end
        chk("t3_blank_loads", 32'(cnt_b), 32'd1);
        chk("t3_underrun", 32'(bus.underrun_o), 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_underrun_held", 32'(bus.underrun_o), 32'd1);
        #1;

        // prefetch limit: 10 offered, wpl=4
        cnt_a = 0;
        bus.word_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.word_dat_i = 16'h1000 + 16'(i);
            if (bus.word_ready_o) cnt_a++;
            @(negedge clk); #1;
        end
        bus.word_valid_i = 1'b0;
        chk("t4_accepted", 32'(cnt_a), 32'd4);
        chk("t4_ready_low", 32'(bus.word_ready_o), 32'd0);
        start_line(2'd2, 4, 4);
        @(negedge clk);
        chk("t4_underrun_cleared", 32'(bus.underrun_o), 32'd0);
        chk("t4_first_word", 32'(bus.sr_dat_o), 32'h1000);
        wait_done();
        chk("t4_ready_back", 32'(bus.word_ready_o), 32'd1);

        // disturbances mid-line must not alter the sequence
        push_word(16'h0001); push_word(16'h0002); push_word(16'h0003); push_word(16'h0004);
        start_line(2'd1, 4, 1);
        cnt_s = 0; cnt_l = 0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            cnt_s += bus.sr_shift2_o ? 1 : 0;
            cnt_l += bus.sr_load_o ? 1 : 0;
            #1;
            bus.line_start_i = (i == 5) || (i == 20);
            if (i == 8)  bus.bpp_i = 2'd0;
            if (i == 15) bus.bpp_i = 2'd3;
        end
        bus.line_start_i = 1'b0;
        chk("t5_shift2", 32'(cnt_s), 32'd28);
        chk("t5_loads", 32'(cnt_l), 32'd4);
        wait_done();

        // reset mid-line, then a normal one-word line
        push_word(16'h1234);
        start_line(2'd0, 1, 1);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_reset_outputs", {bus.sr_dat_o, bus.sr_load_o, bus.sr_shift1_o, bus.active_o,
                                 bus.underrun_o}, 32'd0);
        chk("t6_reset_ready", 32'(bus.word_ready_o), 32'd1);
        #1 rst = 1'b0;
        push_word(16'h9ABC);
        start_line(2'd0, 1, 1);
        @(negedge clk);
        chk("t6_load", {bus.sr_load_o, bus.sr_dat_o}, {15'd0, 1'b1, 16'h9ABC});
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t expected<200000", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
